dst_wb_writer: RTL and testbench

Write-back stage of the DMA datapath. Drains 64-bit words from the destination FIFO, which is filled by the operation stages (fill, copy, etc.), and writes them to system memory as Wishbone incrementing bursts. Sits directly downstream of the `m_dst_*` FIFO and reports completion to the channel controller.

---
 rtl/dst_wb_writer.sv | 185 ++++++++++++++++++
 tb/tb_dst_wb_writer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dst_wb_writer.sv
// Destination write-back stage: drains the m_dst FIFO into Wishbone incrementing write bursts.
// Optional DST_WB_WRITER_SWAP_EN byte-reverses write data for big-endian memory.
module dst_wb_writer #(
    parameter int BURST = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic [31:0] adr_i,
    input  logic [15:0] len_i,
    output logic        m_dst_getn,
    input  logic [63:0] m_dst_q,
    input  logic        m_dst_last,
    input  logic        m_dst_empty,
    output logic [31:0] wbm_adr_o,
    output logic [63:0] wbm_dat_o,
    output logic [7:0]  wbm_sel_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [2:0]  wbm_cti_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_BURST = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_r;
    logic [31:0] adr_r;
    logic [15:0] rem_r;
    logic [4:0]  cnt_r;
    logic [2:0]  cti_r;
    logic        cyc_r;
    logic        err_r;
    logic        done_r;
    logic        busy_r;

    logic        stb_s;
    logic        accept_s;
    logic        bus_err_s;
    logic        flush_pop_s;
    logic [4:0]  wofs_s;
    logic [4:0]  room_s;
    logic [4:0]  beats_s;

`ifdef DST_WB_WRITER_SWAP_EN
    function automatic logic [63:0] byte_swap(input logic [63:0] d);
        logic [63:0] r;
        r = 64'h0;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = d[8*(7-i) +: 8];
        end
        return r;
    endfunction
`endif

    // Handshake decode and burst sizing from the current state and FIFO flags
    always_comb begin
        stb_s       = (state_r == S_BURST) && !m_dst_empty;
        bus_err_s   = stb_s && wbm_err_i;
        accept_s    = stb_s && wbm_ack_i && !wbm_err_i;
        flush_pop_s = (state_r == S_FLUSH) && !m_dst_empty && (rem_r != 16'd0);
        // Beats left before the next BURST*8-byte aligned boundary
        wofs_s      = adr_r[7:3] & 5'(BURST - 1);
        room_s      = 5'(BURST) - wofs_s;
        if (rem_r < {11'd0, room_s}) begin
            beats_s = rem_r[4:0];
        end else begin
            beats_s = room_s;
        end
    end

    // Control FSM with registered bus and status outputs
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r <= S_IDLE;
            adr_r   <= 32'd0;
            rem_r   <= 16'd0;
            cnt_r   <= 5'd0;
            cti_r   <= 3'b000;
            cyc_r   <= 1'b0;
            err_r   <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        adr_r   <= adr_i & ~32'h0000_0007;
                        rem_r   <= len_i;
                        err_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Zero-length transfers also pass through here so done lands two cycles after start
                    if (rem_r == 16'd0) begin
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        cnt_r   <= beats_s;
                        cti_r   <= (beats_s == 5'd1) ? 3'b111 : 3'b010;
                        cyc_r   <= 1'b1;
                        state_r <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (bus_err_s) begin
                        err_r   <= 1'b1;
                        cyc_r   <= 1'b0;
                        adr_r   <= adr_r + 32'd8;
                        rem_r   <= m_dst_last ? 16'd0 : rem_r - 16'd1;
                        state_r <= S_FLUSH;
                    end else if (accept_s) begin
                        adr_r <= adr_r + 32'd8;
                        rem_r <= rem_r - 16'd1;
                        cnt_r <= cnt_r - 5'd1;
                        if ((cnt_r == 5'd1) || m_dst_last) begin
                            cyc_r <= 1'b0;
                            if ((cnt_r == 5'd1) && (rem_r != 16'd1) && !m_dst_last) begin
                                state_r <= S_REQ;
                            end else begin
                                done_r  <= 1'b1;
                                state_r <= S_DONE;
                            end
                        end else begin
                            cti_r <= (cnt_r == 5'd2) ? 3'b111 : 3'b010;
                        end
                    end
                end
                S_FLUSH: begin
                    if (rem_r == 16'd0) begin
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else if (!m_dst_empty) begin
                        rem_r <= m_dst_last ? 16'd0 : rem_r - 16'd1;
                        if ((rem_r == 16'd1) || m_dst_last) begin
                            done_r  <= 1'b1;
                            state_r <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    cyc_r   <= 1'b0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign m_dst_getn = !(accept_s || bus_err_s || flush_pop_s);
    assign wbm_adr_o  = adr_r;
`ifdef DST_WB_WRITER_SWAP_EN
    assign wbm_dat_o  = byte_swap(m_dst_q);
`else
    assign wbm_dat_o  = m_dst_q;
`endif
    assign wbm_sel_o  = 8'hFF;
    assign wbm_cyc_o  = cyc_r;
    assign wbm_we_o   = cyc_r;
    assign wbm_stb_o  = stb_s;
    assign wbm_cti_o  = cti_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_dst_wb_writer.sv
// Randomized bench for dst_wb_writer: queue-based FIFO and slave, burst-plan reference model.
module tb_dst_wb_writer;
    localparam int BURST = 8;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        start;
    logic [31:0] adr_i;
    logic [15:0] len_i;
    logic        m_dst_getn;
    logic [63:0] m_dst_q;
    logic        m_dst_last;
    logic        m_dst_empty;
    logic [31:0] wbm_adr_o;
    logic [63:0] wbm_dat_o;
    logic [7:0]  wbm_sel_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [2:0]  wbm_cti_o;
    logic        wbm_ack_i, wbm_err_i;
    logic        busy, done, err;

    dst_wb_writer #(.BURST(BURST)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .adr_i(adr_i), .len_i(len_i),
        .m_dst_getn(m_dst_getn), .m_dst_q(m_dst_q), .m_dst_last(m_dst_last), .m_dst_empty(m_dst_empty),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_cti_o(wbm_cti_o), .wbm_ack_i(wbm_ack_i),
        .wbm_err_i(wbm_err_i), .busy(busy), .done(done), .err(err)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [63:0] d;
        logic [2:0]  c;
    } beat_t;

    logic [63:0] fq[$];
    bit          fl[$];

    function automatic logic [63:0] mem_view(input logic [63:0] d);
        logic [63:0] r;
`ifdef DST_WB_WRITER_SWAP_EN
        for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
`else
        r = d;
`endif
        return r;
    endfunction

    task automatic drive_fifo(input bit stall);
        m_dst_empty = (fq.size() == 0) || stall;
        m_dst_q     = (fq.size() != 0) ? fq[0] : 64'h0;
        m_dst_last  = (fq.size() != 0) ? fl[0] : 1'b0;
    endtask

    task automatic run_xfer(input logic [31:0] a, input int len, input int lastpos,
                            input int errbeat, input int stall_pct, input int ack_pct);
        logic [63:0] words[$];
        beat_t       eq[$];
        beat_t       bt;
        logic [31:0] aa;
        int n_words, r, room, n, i, b, pops, first_cyc, last_acc, done_idx, gap;
        bit stop, will_err, err_done, pend_pop, seen_cyc, stall;

        n_words = (lastpos >= 0 && lastpos < len) ? lastpos + 1 : len;
        for (int k = 0; k < n_words; k++) begin
            words.push_back({$urandom, $urandom});
            fq.push_back(words[k]);
            fl.push_back(k == lastpos);
        end
        // Reference plan: split at BURST*8-byte boundaries, stop at length or last-flagged word
        aa = a & ~32'h7; r = len; i = 0; stop = 0;
        while (r > 0 && !stop) begin
            room = BURST - int'((aa >> 3) % BURST);
            n = (r < room) ? r : room;
            for (int k = 0; k < n && !stop; k++) begin
                bt.a = aa; bt.d = words[i]; bt.c = (k == n - 1) ? 3'b111 : 3'b010;
                eq.push_back(bt);
                if (i == lastpos) stop = 1;
                aa = aa + 32'd8; r--; i++;
            end
        end
        will_err = (errbeat >= 0) && (errbeat < eq.size());

        @(negedge wb_clk_i);
        start = 1'b1; adr_i = a; len_i = 16'(len);
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; drive_fifo(1'b0);
        b = 0; pops = 0; first_cyc = -1; last_acc = -10; done_idx = -1; gap = 0;
        err_done = 0; pend_pop = 0; seen_cyc = 0;
        for (int k = 1; k < 500 && done_idx < 0; k++) begin
            @(negedge wb_clk_i);
            start = 1'b0;
            if (pend_pop) begin void'(fq.pop_front()); void'(fl.pop_front()); end
            stall = ($urandom_range(99) < stall_pct);
            wbm_ack_i = ($urandom_range(99) < ack_pct);
            wbm_err_i = will_err && !err_done && (b == errbeat);
            if (wbm_err_i) wbm_ack_i = 1'b0;
            drive_fifo(stall);
            #1;
            check("stb", wbm_stb_o, wbm_cyc_o && !m_dst_empty);
            if (wbm_cyc_o) begin
                if (first_cyc < 0) first_cyc = k;
                if (gap > 0) check("gap", gap, 1);
                gap = 0; seen_cyc = 1;
            end else if (seen_cyc && busy && !done) begin
                gap++;
            end
            if (wbm_stb_o && (wbm_ack_i || wbm_err_i)) begin
                if (b < eq.size()) begin
                    check("adr", wbm_adr_o, eq[b].a);
                    check("dat", wbm_dat_o, mem_view(eq[b].d));
                    check("cti", wbm_cti_o, eq[b].c);
                    check("we_sel", {wbm_we_o, wbm_sel_o}, 9'h1FF);
                end else begin
                    check("extra_beat", b, eq.size());
                end
                if (wbm_err_i) err_done = 1; else last_acc = k;
                b++;
            end
            pend_pop = !m_dst_getn;
            if (pend_pop) pops++;
            if (done) done_idx = k;
        end
        if (done_idx < 0) begin
            check("done_timeout", 0, 1);
        end else begin
            check("done_err", err, will_err);
            check("beats", b, will_err ? errbeat + 1 : eq.size());
            check("pops", pops, n_words);
            if (len == 0) begin
                check("len0_done", done_idx, 2);
                check("len0_nocyc", first_cyc, -1);
            end else begin
                check("first_cyc", first_cyc, 2);
                if (!will_err) check("done_lat", done_idx, last_acc + 1);
            end
        end
        @(negedge wb_clk_i);
        if (pend_pop) begin void'(fq.pop_front()); void'(fl.pop_front()); end
        drive_fifo(1'b0);
        #1;
        check("busy_fall", {busy, done}, 2'b00);
        check("fifo_left", fq.size(), 0);
        fq.delete(); fl.delete();
    endtask

    initial begin
        int len, lp, eb;
        wb_rst_i = 1'b1; start = 1'b0; adr_i = 32'h0; len_i = 16'h0;
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; drive_fifo(1'b0);
        #12;
        check("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cti_o}, 6'b0);
        check("rst_stat", {busy, done, err, m_dst_getn}, 4'b0001);
        check("rst_adr", wbm_adr_o, 32'h0);
        m_dst_q = 64'h0011223344556677;
        #1;
`ifdef DST_WB_WRITER_SWAP_EN
        check("swap", wbm_dat_o, 64'h7766554433221100);
`else
        check("swap", wbm_dat_o, 64'h0011223344556677);
`endif
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        run_xfer(32'h0000_1000, 3, -1, -1, 0, 100);
        run_xfer(32'h0000_1030, 10, -1, -1, 0, 100);
        run_xfer(32'h0000_2005, 4, -1, -1, 40, 100);
        run_xfer(32'h0000_3000, 4, -1, 1, 0, 100);
        run_xfer(32'h0000_4000, 5, 1, -1, 0, 100);
        run_xfer(32'h0000_5000, 0, -1, -1, 0, 100);
        run_xfer(32'hFFFF_FFE8, 6, -1, -1, 20, 70);

        for (int t = 0; t < 30; t++) begin
            len = $urandom_range(20);
            lp  = ($urandom_range(2) == 0) ? $urandom_range(len) : -1;
            eb  = ($urandom_range(3) == 0) ? $urandom_range(len) : -1;
            run_xfer($urandom, len, lp, eb, $urandom_range(40), 50 + $urandom_range(50));
        end

        // Asynchronous reset while a burst is stalled on ack
        for (int k = 0; k < 4; k++) begin fq.push_back(64'(k)); fl.push_back(1'b0); end
        @(negedge wb_clk_i);
        start = 1'b1; adr_i = 32'h6000; len_i = 16'd4; wbm_ack_i = 1'b0; drive_fifo(1'b0);
        @(negedge wb_clk_i); start = 1'b0;
        @(negedge wb_clk_i); @(negedge wb_clk_i);
        #1;
        check("pre_rst_cyc", {wbm_cyc_o, wbm_stb_o}, 2'b11);
        #1 wb_rst_i = 1'b1;
        #1;
        check("async_rst_bus", {wbm_cyc_o, wbm_stb_o, busy, m_dst_getn}, 4'b0001);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        fq.delete(); fl.delete(); drive_fifo(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
